alu_muldiv_seq: RTL
===================

Name: alu_muldiv_seq

Overview:
Multi-cycle unsigned multiply/divide sequencer for the 16-bit execute stage. It sits beside the single-cycle ALU and iterates one shift-add (MUL) or restoring shift-subtract (DIV) step per clock. It exposes a start/busy/done handshake so the pipeline control can stall decode/execute while it runs. Result registers hold the last completed result until the next accepted start.

Parameters:
WIDTH, 16, operand width; result is 2*WIDTH split into hi/lo
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
op  input  1  0 = MUL, 1 = DIV
sgn  input  1  signed operation; used only when ALU_MULDIV_SIGNED_EN is defined, otherwise ignored
flush  input  1  synchronous abort of an in-flight operation
a_in  input  WIDTH  multiplicand / dividend
b_in  input  WIDTH  multiplier / divisor
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: results valid
res_lo  output  WIDTH  MUL: product[15:0]; DIV: quotient
res_hi  output  WIDTH  MUL: product[31:16]; DIV: remainder
div_by_zero  output  1  DIV with b_in == 0; valid with done, held with results

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; busy = 0, done = 0, res_lo = 0, res_hi = 0, div_by_zero = 0.
  - Working registers and counter cleared.
  - Reset mid-RUN abandons the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1, flush=0, at edge k:
  - Latch a_in, b_in, op and sgn into working registers; counter = 0.
  - If op=1 and b_in == 0: go directly to DONE. Set res_lo = 0xFFFF, res_hi = a_in and div_by_zero = 1. done is high in the cycle after edge k.
  - Otherwise go to RUN.
- RUN:
  - One iteration per edge; counter increments.
  - At the WIDTH-th iteration edge (edge k+WIDTH), results are written into res_lo/res_hi, div_by_zero = 0, and state goes to DONE.
  - done is high exactly WIDTH cycles after the accepting edge (16 by default).
- MUL: 2*WIDTH accumulator, shift-add, unsigned; no overflow possible.
- DIV: restoring division; remainder register WIDTH+1 bits for the trial subtract.
  - Invariant for unsigned: a = q*b + r, r < b.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - A start in DONE is accepted exactly as in IDLE (back-to-back operations, no bubble).
- busy = 1 only in RUN. A start while busy is ignored, with no queuing.
- flush:
  - flush=1 at any edge forces IDLE with no done pulse.
  - res_lo/res_hi/div_by_zero keep their previous completed values.
  - flush and start in the same cycle: flush wins and start is dropped.
- Outputs are registered (no combinational path from inputs to outputs).

Optional Feature:
ALU_MULDIV_SIGNED_EN
- Defined, with sgn=1:
  - Operands are converted to magnitude at accept.
  - Results are sign-corrected on the final iteration edge, so latency is unchanged.
  - MUL: product negated if signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x8000 / 0xFFFF gives q = 0x8000, r = 0.
  - Divide-by-zero behaves as in the unsigned case.
- Undefined: sgn is ignored and all operations are unsigned; no sign logic is synthesized.

Test Plan:
1. MUL: a=0x1234, b=0x0010, start at edge k -> busy for cycles k+1..k+16; done at k+16 exactly once; res_hi=0x0001, res_lo=0x2340.
2. MUL: 0xFFFF*0xFFFF -> res_hi=0xFFFE, res_lo=0x0001; then a DIV start in the DONE cycle is accepted with no idle gap.
3. DIV: a=100, b=7 -> res_lo=0x000E, res_hi=0x0002, div_by_zero=0 after 16 cycles; a second start pulsed mid-RUN is ignored.
4. DIV: a=0x0055, b=0 -> done in the cycle after accept, res_lo=0xFFFF, res_hi=0x0055, div_by_zero=1, busy never asserted.
5. flush at RUN cycle 5 (previous result 0x0001/0x2340) -> IDLE next edge, no done, results still 0x0001/0x2340. Then rst asserted mid-RUN -> all outputs 0 immediately.
6. With ALU_MULDIV_SIGNED_EN and sgn=1:
   - -6*7 -> res_hi=0xFFFF, res_lo=0xFFD6.
   - -7/2 -> res_lo=0xFFFD, res_hi=0xFFFF.
   - 0x8000/0xFFFF -> res_lo=0x8000, res_hi=0.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned multiply / restoring divide sequencer.
// One iteration per clock, start/busy/done handshake, results held until the
// next accepted start. Define ALU_MULDIV_SIGNED_EN to add signed operation
// (sgn=1): operands become magnitudes at accept, results are sign-corrected on
// the final iteration edge so latency does not change.
// CNT_W must satisfy 2**CNT_W > WIDTH.
module alu_muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic             flush,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  // a_q: multiplicand (MUL); b_q: multiplier seed / divisor
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // hi_q: MUL upper accumulator / DIV partial remainder (one spare bit)
  logic [WIDTH:0]   hi_q, hi_d;
  // lo_q: MUL multiplier shifting out / DIV dividend shifting into quotient
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic [WIDTH-1:0] fin_lo_s, fin_hi_s;
  logic             accept_s, zero_div_s, last_iter_s;

`ifdef ALU_MULDIV_SIGNED_EN
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             neg_acc_s, rneg_acc_s;
  logic [2*WIDTH-1:0] prod_s;
`else
  // sgn has no function in the unsigned-only build
  logic             unused_sgn_s;
  assign unused_sgn_s = sgn;
`endif

  assign accept_s    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !flush;
  assign zero_div_s  = op && (b_in == {WIDTH{1'b0}});
  assign last_iter_s = (cnt_q == CNT_W'(WIDTH - 1));

  // Operand conditioning at accept: magnitudes and result sign flags
  always_comb begin
    a_mag_s = a_in;
    b_mag_s = b_in;
`ifdef ALU_MULDIV_SIGNED_EN
    neg_acc_s  = 1'b0;
    rneg_acc_s = 1'b0;
    if (sgn) begin
      if (a_in[WIDTH-1]) begin
        a_mag_s = {WIDTH{1'b0}} - a_in;
      end else begin
        a_mag_s = a_in;
      end
      if (b_in[WIDTH-1]) begin
        b_mag_s = {WIDTH{1'b0}} - b_in;
      end else begin
        b_mag_s = b_in;
      end
      neg_acc_s  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
      rneg_acc_s = a_in[WIDTH-1];
    end else begin
      neg_acc_s  = 1'b0;
      rneg_acc_s = 1'b0;
    end
`endif
  end

  // One shift-add (MUL) or restoring shift-subtract (DIV) iteration
  always_comb begin
    mul_sum_s   = hi_q + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    step_hi_s   = hi_q;
    step_lo_s   = lo_q;
    if (op_q) begin
      if (div_shift_s >= {1'b0, b_q}) begin
        step_hi_s = div_shift_s - {1'b0, b_q};
        step_lo_s = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = div_shift_s;
        step_lo_s = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi_s = {1'b0, mul_sum_s[WIDTH:1]};
      step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Final result formation, including sign correction when enabled
  always_comb begin
    fin_lo_s = step_lo_s;
    fin_hi_s = step_hi_s[WIDTH-1:0];
`ifdef ALU_MULDIV_SIGNED_EN
    prod_s = {step_hi_s[WIDTH-1:0], step_lo_s};
    if (!op_q) begin
      if (neg_q) begin
        prod_s = {(2*WIDTH){1'b0}} - prod_s;
      end else begin
        prod_s = {step_hi_s[WIDTH-1:0], step_lo_s};
      end
      fin_lo_s = prod_s[WIDTH-1:0];
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end else begin
      if (neg_q) begin
        fin_lo_s = {WIDTH{1'b0}} - step_lo_s;
      end else begin
        fin_lo_s = step_lo_s;
      end
      if (rneg_q) begin
        fin_hi_s = {WIDTH{1'b0}} - step_hi_s[WIDTH-1:0];
      end else begin
        fin_hi_s = step_hi_s[WIDTH-1:0];
      end
    end
`endif
  end

  // Next-state and working/result register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
`ifdef ALU_MULDIV_SIGNED_EN
    neg_d    = neg_q;
    rneg_d   = rneg_q;
`endif
    if (flush) begin
      // abort: results keep their last completed values
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            cnt_d = {CNT_W{1'b0}};
            op_d  = op;
            a_d   = a_mag_s;
            b_d   = b_mag_s;
            hi_d  = {(WIDTH+1){1'b0}};
            lo_d  = op ? a_mag_s : b_mag_s;
`ifdef ALU_MULDIV_SIGNED_EN
            neg_d  = neg_acc_s;
            rneg_d = rneg_acc_s;
`endif
            if (zero_div_s) begin
              // divide by zero completes immediately with fixed results
              state_d  = S_DONE;
              res_lo_d = {WIDTH{1'b1}};
              res_hi_d = a_in;
              dbz_d    = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          hi_d  = step_hi_s;
          lo_d  = step_lo_s;
          if (last_iter_s) begin
            state_d  = S_DONE;
            res_lo_d = fin_lo_s;
            res_hi_d = fin_hi_s;
            dbz_d    = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      op_q     <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      hi_q     <= {(WIDTH+1){1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
`ifdef ALU_MULDIV_SIGNED_EN
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign res_lo      = res_lo_q;
  assign res_hi      = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule
